dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory (word array with registered read, byte write enables, 1-cycle read latency). It lets the core load/store unit (port 0) and the memory loader/DMA engine (port 1) share the memory. It grants one request per cycle and tracks which port owns each in-flight read so the registered read data returns to the right requester. Port 0 has fixed priority, with a starvation counter that guarantees port 1 forward progress.

## Interface

Parameters:
- ADD_WIDTH, 18: byte-address width forwarded to memory; must match memory instance.
- STARVE_LIMIT, 4: consecutive contended cycles port 1 may lose before it is forced to win; range 1..15.

Ports (reset is synchronous, active-high; one clock):
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous active-high reset
- m0_req  input  1  port 0 request valid
- m0_wen  input  4  port 0 byte write enables; 0 = read
- m0_add  input  32  port 0 byte address
- m0_wdata  input  32  port 0 write data
- m0_gnt  output  1  port 0 request accepted this cycle
- m0_rvalid  output  1  port 0 read data valid
- m0_rdata  output  32  port 0 read data
- m1_req, m1_wen, m1_add, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- mem_add  output  32  address to memory
- mem_wen  output  4  byte write enables to memory
- mem_wdata  output  32  write data to memory
- mem_rdata  input  32  registered read data from memory, valid 1 cycle after address

## Operation

- Requester holds req/wen/add/wdata stable until it sees gnt high at a rising edge. A transfer completes at that edge.
- Arbitration is combinational within the cycle:
  - Only one port requesting: that port wins.
  - Both requesting: port 0 wins unless starve_cnt == STARVE_LIMIT, in which case port 1 wins.
- The winner's add/wen/wdata drive mem_*. With no grant: mem_wen = 0, mem_add/mem_wdata = port 0 values (don't-care, but must be deterministic).
- starve_cnt (4 bits):
  - increments when m1_req and m0 is granted;
  - clears when m1 is granted or m1_req is low;
  - saturates at STARVE_LIMIT.
- Read ownership register rd_own ∈ {NONE, P0, P1}:
  - loaded each cycle with the granted port if that grant was a read (wen == 0);
  - otherwise loaded with NONE.
- Return path:
  - mX_rvalid = (rd_own == PX).
  - mX_rdata = mem_rdata when rd_own == PX, else 0.
- Writes produce no response. gnt is the completion.
- Back-to-back: a new grant may be issued in the same cycle as the return of the previous read. Full throughput is one access per cycle.

## Timing

- Grant latency: 0 cycles, combinational from req. gnt never depends on rvalid.
- Read latency: rvalid is high exactly 1 cycle after the granting edge, for exactly 1 cycle.
- Write: memory is updated at the granting edge.
- Reset:
  - While reset is high: m0_gnt = m1_gnt = 0 and mem_wen = 0 (gated combinationally).
  - At the reset edge: rd_own <= NONE, starve_cnt <= 0.
  - Hence rvalid = 0 and rdata = 0 in the cycle after any reset cycle.
- Reset mid-operation: a read granted the cycle before reset is dropped. No rvalid is issued after reset asserts.
- Simultaneous port 0 write and port 1 read to the same address: port 0 is granted first. Port 1's later read returns the new data.
- Worst-case port 1 wait under continuous port 0 traffic: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1.

## Structure

- Shared package dmem_pkg:
  - owner enum (OWN_NONE, OWN_P0, OWN_P1);
  - STARVE_LIMIT default;
  - WEN_READ = 4'b0000 constant.
- One natural sub-module, dmem_prio_arb: two-requester priority/starvation logic producing one-hot grant and owning starve_cnt. Muxing and the return path live in dmem_arbiter.
- Bench instantiates dmem_arbiter with the real data memory on the mem_* side.

## Test plan

- Reset then port 0 read of 0x10 preloaded 0xDEADBEEF → m0_gnt same cycle, m0_rvalid=1 with 0xDEADBEEF next cycle, m1_rvalid stays 0.
- Port 1 writes 0x000000AA to 0x20 with wen=4'b0001, then reads 0x20 → byte 0 = 0xAA, other bytes unchanged. One rvalid, on port 1 only.
- Both ports request reads every cycle, STARVE_LIMIT=4 → pattern P0,P0,P0,P0,P1 repeating. Each rvalid is routed to the correct port with matching data.
- Port 0 read granted at cycle N, port 1 read granted at N+1 → m0_rvalid at N+1, m1_rvalid at N+2, no overlap, no bubble.
- Port 0 read granted, reset asserted next cycle → no rvalid after reset. gnt=0 and mem_wen=0 throughout reset, counter reads 0 afterward.
- Same-cycle port 0 write 0x12345678 and port 1 read at 0x40 → port 0 granted first. Port 1's read, granted next cycle, returns 0x12345678.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory arbiter
// Purpose: read-ownership encoding, default starvation limit and the
//          write-enable value that marks a read access.
// Ports:   none (package)
package dmem_pkg;

  // Which requester owns the read data returning from memory this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam int         STARVE_LIMIT_DEFAULT = 4;
  localparam logic [3:0] WEN_READ             = 4'b0000;

endpackage

// File: rtl/dmem_prio_arb.sv
// rtl/dmem_prio_arb.sv - two-requester fixed-priority arbiter with starvation guard
// Purpose: grants requester 0 by default. Requester 1 is forced to win once
//          it has lost STARVE_LIMIT consecutive contended cycles.
// Ports:   clk, reset       - clock, synchronous active-high reset
//          req0, req1       - request valids
//          gnt[1:0]         - one-hot grant (bit0 = requester 0), zero in reset
//          starve_cnt[3:0]  - consecutive losses of requester 1
module dmem_prio_arb
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  output logic [1:0] gnt,
  output logic [3:0] starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic force1;

  always_comb begin
    force1 = (starve_cnt == LIMIT);
    gnt    = 2'b00;
    if (!reset) begin
      if (req0 && req1) begin
        gnt = force1 ? 2'b10 : 2'b01;
      end else begin
        gnt = {req1, req0};
      end
    end
  end

  // Counts only while requester 1 is waiting behind requester 0; any cycle
  // where requester 1 wins or stops asking starts the count over.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!req1 || gnt[1]) begin
      starve_cnt <= 4'd0;
    end else if (gnt[0] && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for the single-ported data memory
// Purpose: one access per cycle to a memory with 1-cycle registered read.
//          Port 0 (load/store unit) has priority, port 1 (loader/DMA) is
//          protected from starvation. Read data is steered back to the port
//          that issued the read.
// Ports:   clk, reset                      - clock, synchronous active-high reset
//          mX_req/wen/add/wdata            - port X request (wen == 0 is a read)
//          mX_gnt                          - port X accepted this cycle
//          mX_rvalid/rdata                 - port X read return
//          mem_add/wen/wdata               - access presented to memory
//          mem_rdata                       - registered memory read data
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADD_WIDTH    = 18,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [3:0]  m0_wen,
  input  logic [31:0] m0_add,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [3:0]  m1_wen,
  input  logic [31:0] m1_add,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_add,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Only the low ADD_WIDTH address bits reach the memory instance.
  localparam logic [31:0] ADD_MASK =
      (ADD_WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ADD_WIDTH) - 32'd1);

  logic [1:0]  gnt;
  logic [3:0]  starve_cnt;
  logic [31:0] sel_add;
  owner_t      rd_own;
  owner_t      rd_own_nxt;

  dmem_prio_arb #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req0       (m0_req),
    .req1       (m1_req),
    .gnt        (gnt),
    .starve_cnt (starve_cnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // Port 0 values are parked on the bus when idle so the bus never floats
  // to an undefined value; mem_wen = 0 makes that a harmless read.
  always_comb begin
    sel_add    = m0_add;
    mem_wdata  = m0_wdata;
    mem_wen    = WEN_READ;
    rd_own_nxt = OWN_NONE;
    if (gnt[1]) begin
      sel_add   = m1_add;
      mem_wdata = m1_wdata;
      mem_wen   = m1_wen;
      if (m1_wen == WEN_READ) rd_own_nxt = OWN_P1;
    end else if (gnt[0]) begin
      mem_wen = m0_wen;
      if (m0_wen == WEN_READ) rd_own_nxt = OWN_P0;
    end
  end

  assign mem_add = sel_add & ADD_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_own <= OWN_NONE;
    end else begin
      rd_own <= rd_own_nxt;
    end
  end

  // A read granted just before reset is dropped: its return is masked in
  // the reset cycle itself, and rd_own is cleared at the reset edge.
  assign m0_rvalid = (rd_own == OWN_P0) && !reset;
  assign m1_rvalid = (rd_own == OWN_P1) && !reset;
  assign m0_rdata  = m0_rvalid ? mem_rdata : 32'd0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : 32'd0;

  logic unused_cnt;
  assign unused_cnt = ^starve_cnt;

endmodule
